// File: rtl/testcore_sysid_checker.sv
// testcore_sysid_checker
//   Avalon-MM read master that reads the system-ID slave (word 0 = system ID,
//   word 1 = build timestamp), captures both words and compares them against
//   the expected build. The result is held in sticky flags for status LEDs or
//   a host-visible register.
//
// Parameters
//   EXPECT_ID         expected word 0
//   EXPECT_TIMESTAMP  expected word 1
//   TIMEOUT_CYCLES    per-transaction cycle limit (1..65535)
//   AUTO_START        1: one check launches on the first cycle after reset
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   start                        one-cycle check request, ignored while busy
//   avm_address, avm_read        read command (word address, request)
//   avm_waitrequest              slave stall; accept = avm_read & ~avm_waitrequest
//   avm_readdata, avm_readdatavalid  read response
//   busy                         check in progress
//   done, pass, timeout          sticky result of the last check
//   id_value, timestamp_value    captured words (0 if never captured)
module testcore_sysid_checker #(
  parameter logic [31:0] EXPECT_ID        = 32'd538186003,
  parameter logic [31:0] EXPECT_TIMESTAMP = 32'd1416068547,
  parameter int unsigned TIMEOUT_CYCLES   = 255,
  parameter bit          AUTO_START       = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    FINISH  = 3'd5
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [15:0] count, count_next;
  logic        auto_pending, auto_pending_next;
  logic        address_next, read_next;
  logic        busy_next, done_next, pass_next, timeout_next;
  logic [31:0] id_next, timestamp_next;
  logic        launch;
  logic        expired;

  // A check may only be launched from a quiet idle; the auto-start request
  // lives for exactly the first cycle after reset.
  assign launch  = (start | auto_pending) & (state == IDLE) & ~busy;
  assign expired = (count == TIMEOUT_LIMIT);

  always_comb begin
    state_next        = state;
    count_next        = count;
    auto_pending_next = 1'b0;
    address_next      = avm_address;
    read_next         = avm_read;
    done_next         = done;
    pass_next         = pass;
    timeout_next      = timeout;
    id_next           = id_value;
    timestamp_next    = timestamp_value;

    case (state)
      IDLE: begin
        if (launch) begin
          state_next     = ID_REQ;
          read_next      = 1'b1;
          address_next   = 1'b0;
          count_next     = '0;
          done_next      = 1'b0;
          pass_next      = 1'b0;
          timeout_next   = 1'b0;
          id_next        = '0;
          timestamp_next = '0;
        end
      end

      ID_REQ, TS_REQ: begin
        count_next = count + 16'd1;
        if (!avm_waitrequest) begin
          // command accepted; exactly one read outstanding from here on
          state_next = (state == ID_REQ) ? ID_WAIT : TS_WAIT;
          read_next  = 1'b0;
        end else if (expired) begin
          state_next   = IDLE;
          read_next    = 1'b0;
          timeout_next = 1'b1;
          pass_next    = 1'b0;
          done_next    = 1'b1;
        end
      end

      ID_WAIT: begin
        count_next = count + 16'd1;
        if (avm_readdatavalid) begin
          id_next      = avm_readdata;
          state_next   = TS_REQ;
          read_next    = 1'b1;
          address_next = 1'b1;
          count_next   = '0;
        end else if (expired) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
          pass_next    = 1'b0;
          done_next    = 1'b1;
        end
      end

      TS_WAIT: begin
        count_next = count + 16'd1;
        if (avm_readdatavalid) begin
          timestamp_next = avm_readdata;
          state_next     = FINISH;
        end else if (expired) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
          pass_next    = 1'b0;
          done_next    = 1'b1;
        end
      end

      FINISH: begin
        done_next  = 1'b1;
        pass_next  = (id_value == EXPECT_ID) && (timestamp_value == EXPECT_TIMESTAMP);
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        read_next  = 1'b0;
      end
    endcase

    // busy rises with the launch and stays up through the cycle in which the
    // result flags first become visible, so a host never sees done with busy
    // already low on the same cycle.
    busy_next = (state_next != IDLE) || (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      auto_pending    <= AUTO_START;
      avm_address     <= 1'b0;
      avm_read        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      state           <= state_next;
      count           <= count_next;
      auto_pending    <= auto_pending_next;
      avm_address     <= address_next;
      avm_read        <= read_next;
      busy            <= busy_next;
      done            <= done_next;
      pass            <= pass_next;
      timeout         <= timeout_next;
      id_value        <= id_next;
      timestamp_value <= timestamp_next;
    end
  end

endmodule

// File: tb/tb_testcore_sysid_checker.sv
module tb_testcore_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd538186003;
  localparam logic [31:0] EXP_TS = 32'd1416068547;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_address, avm_read, busy, done, pass, timeout;
  logic [31:0] id_value, timestamp_value;

  always #5 clock = ~clock;

  testcore_sysid_checker #(
    .EXPECT_ID       (EXP_ID),
    .EXPECT_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES  (8),
    .AUTO_START      (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .timeout          (timeout),
    .id_value         (id_value),
    .timestamp_value  (timestamp_value)
  );

  int edge_count = 0;
  always @(posedge clock) edge_count++;

  // slave model configuration (written by the main sequence only)
  int          stall_cycles = 0;
  int          latency = 1;
  logic [31:0] id_data = EXP_ID;
  logic [31:0] ts_data = EXP_TS;
  bit          drop_ts = 1'b0;
  int          inject_seq = 0;

  // slave statistics (written by the slave only)
  int accepts = 0;
  int ts_read_starts = 0;
  int stall_viol = 0;

  // Avalon-MM slave model: reacts to what the DUT presented at each edge,
  // then updates its own outputs 1 ns later.
  initial begin : slave
    int          resp_cnt;
    bit          resp_active;
    logic [31:0] resp_data;
    int          stalls_done;
    int          inject_done;
    bit          accepted, stalled, prev_read;
    logic        cmd_addr;
    resp_cnt = 0; resp_active = 0; resp_data = '0; stalls_done = 0;
    inject_done = 0; prev_read = 0;
    forever begin
      @(posedge clock);
      accepted = avm_read && !avm_waitrequest;
      stalled  = avm_read && avm_waitrequest;
      cmd_addr = avm_address;
      #1;
      if (stalled && !reset && !timeout && !(avm_read && avm_address == cmd_addr))
        stall_viol++;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      if (reset) begin
        resp_active = 0;
      end else if (accepted) begin
        accepts++;
        if (!(drop_ts && cmd_addr)) begin
          resp_active = 1;
          resp_cnt    = latency;
          resp_data   = cmd_addr ? ts_data : id_data;
        end
      end
      if (resp_active) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = resp_data;
          resp_active       = 0;
        end
      end
      if (inject_seq != inject_done) begin
        inject_done       = inject_seq;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEADBEEF;
      end
      if (avm_read) begin
        if (!prev_read && avm_address) ts_read_starts++;
        avm_waitrequest = (stalls_done < stall_cycles);
        stalls_done++;
      end else begin
        stalls_done     = 0;
        avm_waitrequest = 1'b0;
      end
      prev_read = avm_read;
    end
  end

  typedef struct {
    logic        pass_e;
    logic        to_e;
    logic [31:0] id_e;
    logic [31:0] ts_e;
    int          lat_e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   e0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic p, input logic t, input logic [31:0] i,
                          input logic [31:0] s, input int l);
    exp_t e;
    e.pass_e = p; e.to_e = t; e.id_e = i; e.ts_e = s; e.lat_e = l;
    sb.push_back(e);
  endtask

  // pulse start for one edge (E0); returns 1 ns after E0
  task automatic launch_start();
    @(negedge clock);
    start = 1'b1;
    e0 = edge_count + 1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_and_check(input string tag);
    exp_t e;
    bit   seen;
    int   elapsed;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    elapsed = edge_count - e0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_queue"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_pass"}, 32'(pass), 32'(e.pass_e));
      check({tag, "_timeout"}, 32'(timeout), 32'(e.to_e));
      check({tag, "_id"}, id_value, e.id_e);
      check({tag, "_ts"}, timestamp_value, e.ts_e);
      check({tag, "_latency"}, 32'(elapsed), 32'(e.lat_e));
      if (!e.to_e) check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    end
    $display("txn %s: edges=%0d pass=%0b timeout=%0b id=0x%08h ts=0x%08h",
             tag, elapsed, pass, timeout, id_value, timestamp_value);
  endtask

  initial begin : main
    int acc0, viol0, ts0;

    // reset state
    repeat (4) @(posedge clock);
    #1;
    check("reset_flags", 32'({busy, done, pass, timeout, avm_read, avm_address}), 32'd0);
    check("reset_id", id_value, 32'd0);
    check("reset_ts", timestamp_value, 32'd0);

    // nominal: auto-start after reset release, L=1, no stalls
    @(negedge clock);
    reset = 1'b0;
    e0 = edge_count + 1;
    push_exp(1'b1, 1'b0, EXP_ID, EXP_TS, 5);
    wait_and_check("nominal");
    @(posedge clock);
    #1;
    check("nominal_busy_drop", 32'(busy), 32'd0);
    check("nominal_done_sticky", 32'(done), 32'd1);

    // mismatching ID
    id_data = 32'h12345678;
    launch_start();
    check("mismatch_clear", 32'({done, pass, timeout}), 32'd0);
    check("mismatch_clear_id", id_value, 32'd0);
    push_exp(1'b0, 1'b0, 32'h12345678, EXP_TS, 5);
    wait_and_check("mismatch");
    repeat (2) @(posedge clock);
    id_data = EXP_ID;

    // stalls of 3 cycles per command, latency 4
    stall_cycles = 3;
    latency = 4;
    acc0 = accepts;
    viol0 = stall_viol;
    launch_start();
    push_exp(1'b1, 1'b0, EXP_ID, EXP_TS, 17);
    wait_and_check("stall");
    check("stall_accepts", 32'(accepts - acc0), 32'd2);
    check("stall_stable", 32'(stall_viol - viol0), 32'd0);
    repeat (2) @(posedge clock);
    stall_cycles = 0;
    latency = 1;

    // timeout on word 1
    drop_ts = 1'b1;
    ts0 = ts_read_starts;
    launch_start();
    push_exp(1'b0, 1'b1, EXP_ID, 32'd0, 11);
    wait_and_check("timeout");
    check("timeout_read_low", 32'(avm_read), 32'd0);
    check("timeout_ts_reads", 32'(ts_read_starts - ts0), 32'd1);
    @(posedge clock);
    #1;
    check("timeout_busy_after", 32'(busy), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("timeout_no_reissue", 32'(ts_read_starts - ts0), 32'd1);
    drop_ts = 1'b0;

    // start pulsed during ID_WAIT is ignored
    latency = 4;
    launch_start();
    push_exp(1'b1, 1'b0, EXP_ID, EXP_TS, 11);
    @(negedge clock);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_and_check("overlap");
    repeat (3) @(posedge clock);
    #1;
    check("overlap_not_queued", 32'(busy), 32'd0);

    // spurious readdatavalid in IDLE
    inject_seq++;
    repeat (3) @(posedge clock);
    #1;
    check("spurious_id", id_value, EXP_ID);
    check("spurious_ts", timestamp_value, EXP_TS);
    check("spurious_idle", 32'({busy, done}), 32'b01);

    // second start after done
    latency = 1;
    launch_start();
    check("restart_clear", 32'({done, pass, timeout}), 32'd0);
    push_exp(1'b1, 1'b0, EXP_ID, EXP_TS, 5);
    wait_and_check("restart");
    repeat (2) @(posedge clock);

    // reset during TS_WAIT
    latency = 4;
    launch_start();
    repeat (6) @(posedge clock);
    #1;
    check("midreset_in_ts_wait", 32'({busy, avm_read, avm_address}), 32'b101);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_flags", 32'({busy, done, pass, timeout, avm_read, avm_address}), 32'd0);
    check("midreset_id", id_value, 32'd0);
    check("midreset_ts", timestamp_value, 32'd0);
    latency = 1;
    @(negedge clock);
    reset = 1'b0;
    e0 = edge_count + 1;
    push_exp(1'b1, 1'b0, EXP_ID, EXP_TS, 5);
    wait_and_check("after_reset");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/testcore_sysid_checker.md
# testcore_sysid_checker

Avalon-MM read master that interrogates the system-ID slave of the testcore and reports whether the fabric carries the expected build. On `start` (or automatically after reset) it reads word 0 (system ID) and word 1 (build timestamp), captures both, and compares them against parameterised expected values. The pass/fail/timeout result is exported for status LEDs or a host-visible register. It sits beside the sysid slave on the same interconnect, as the initiator for that slave.

## Interface
Parameters:
- `EXPECT_ID`, 32'd538186003, expected value of word 0
- `EXPECT_TIMESTAMP`, 32'd1416068547, expected value of word 1
- `TIMEOUT_CYCLES`, 255, per-transaction cycle limit (1..65535); counter width is 16 bits
- `AUTO_START`, 1, if 1, one check launches automatically after reset

Ports:
- `clock` in 1: single clock domain for all logic
- `reset` in 1: synchronous, active-high
- `start` in 1: single-cycle request to begin a check; ignored while `busy`
- `avm_address` out 1: word address, 0 = ID, 1 = timestamp
- `avm_read` out 1: read request
- `avm_waitrequest` in 1: slave stall; the command is accepted when `avm_read & ~avm_waitrequest`
- `avm_readdata` in 32: read data, valid only with `avm_readdatavalid`
- `avm_readdatavalid` in 1: read response strobe
- `busy` out 1: a check is in progress
- `done` out 1: sticky; last check finished
- `pass` out 1: sticky; both words matched, no timeout
- `timeout` out 1: sticky; last check aborted by timeout
- `id_value` out 32: captured word 0
- `timestamp_value` out 32: captured word 1

## Operation
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE
  - `start=1` → ID_REQ.
  - In the same edge, clear `done`, `pass`, `timeout`, `id_value`, and `timestamp_value` to 0.
- ID_REQ
  - `avm_read=1`, `avm_address=0`.
  - Hold both until the command is accepted (`avm_waitrequest=0`), then → ID_WAIT.
- ID_WAIT
  - `avm_read=0`.
  - On `avm_readdatavalid`, capture `avm_readdata` into `id_value` and → TS_REQ.
- TS_REQ and TS_WAIT behave as ID_REQ and ID_WAIT, using `avm_address=1` and capturing into `timestamp_value`.
- FINISH (one cycle)
  - `done=1`.
  - `pass = (id_value==EXPECT_ID) && (timestamp_value==EXPECT_TIMESTAMP)`.
  - Then → IDLE.
- Timeout
  - A 16-bit counter clears on entry to each REQ state and increments every cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` and no accept or valid is seen that cycle: drop `avm_read`, set `timeout=1`, `pass=0`, `done=1`, and → IDLE.
  - Words not yet captured remain 0.
  - Dropping `avm_read` before acceptance is permitted only on this path.
- Only one transaction is outstanding at a time; the block never pipelines reads.
- `avm_readdatavalid` in IDLE, REQ, or FINISH states is ignored; no capture occurs.
- `start` while `busy` is ignored; it is not queued.
- `busy = (state != IDLE)`.
- AUTO_START=1: the first cycle after `reset` deasserts behaves as if `start=1`. This fires once per reset.
- Reset, including mid-transaction, forces:
  - state IDLE
  - `avm_read=0`, `avm_address=0`
  - `busy=0`, `done=0`, `pass=0`, `timeout=0`
  - `id_value=0`, `timestamp_value=0`
  - counter 0
- All outputs are registered.

## Timing
- `start` sampled at edge E0 → `avm_read=1`, `avm_address=0` visible after E0.
- With zero wait states and read latency L≥1:
  - the ID command is accepted at E1;
  - the ID response arrives at E1+L and is captured then;
  - the TS command is accepted at E2+L;
  - the TS response is captured at E2+2L;
  - `done` and `pass` are visible after E3+2L, with `busy` high during that cycle;
  - `busy` drops after E4+2L.
- Minimum start-to-done is 5 edges (L=1).
- Each `avm_waitrequest` stall cycle adds one cycle.
- Readdatavalid arriving on the same edge as the accept is not supported, because the slave latency is at least 1.
- Timeout at count `TIMEOUT_CYCLES`: `timeout` and `done` are visible the following cycle, and `avm_read` is low the same cycle.

## Test plan
- Nominal: `reset` 4 cycles with AUTO_START=1; model slave returns 538186003 / 1416068547 at L=1, no stalls → `done=1`, `pass=1`, `timeout=0` on the 5th edge after reset release; `id_value` and `timestamp_value` match.
- Mismatch: slave returns ID 0x12345678 → `done=1`, `pass=0`, `timeout=0`, `id_value=0x12345678`.
- Stalls/latency: `avm_waitrequest` high 3 cycles per command, L=4 → `avm_address` and `avm_read` stable during the stall; exactly two accepts; `pass=1` at start+17 edges.
- Timeout: TIMEOUT_CYCLES=8; slave never asserts readdatavalid for word 1 → `avm_read` asserted for word 1 only once; `timeout=1`, `pass=0`, `done=1`; `id_value` captured, `timestamp_value=0`; `busy=0` afterwards.
- Spurious and overlap:
  - `start` pulsed in ID_WAIT → ignored.
  - An extra `avm_readdatavalid` in IDLE → no capture.
  - Second `start` after `done` → flags clear, then re-check passes.
- Reset mid-operation: assert `reset` during TS_WAIT → next cycle all outputs 0, state IDLE. With AUTO_START=1, a new check starts after release and passes.
